coin_acceptor: RTL
==================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive identical synchronized samples needed to qualify a level (legal 2..15).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of accepted coins held pending (power of 2, 2..8).
REQ-003 The block SHALL have port clock, input, 1 bit: rising-edge clock for all state.
REQ-004 The block SHALL have port reset_N, input, 1 bit: reset, synchronous, active-low; clock clock.
REQ-005 The block SHALL have port coin_raw, input, 2 bits: asynchronous slot-sensor level; 00 none, 01 circle, 10 triangle, 11 pentagon.
REQ-006 The block SHALL have port drop, input, 1 bit: soda-drop indication from the downstream vending FSM.
REQ-007 The block SHALL have port coin, output, 2 bits: one-cycle coin code to the downstream vending FSM; 00 means no coin.
REQ-008 The block SHALL have port pending, output, $clog2(FIFO_DEPTH)+1 bits: the current FIFO occupancy.
REQ-009 The block SHALL have port reject, output, 1 bit: a one-cycle pulse when a qualified coin is discarded because the FIFO is full.

Function
REQ-010 coin_raw SHALL pass through a 2-flop synchronizer; a raw change before edge k appears at the synchronizer output after edge k+1.
REQ-011 The debounce counter SHALL reset to 1 whenever the synchronized value differs from the previous sample, and SHALL increment otherwise, saturating at DEBOUNCE_CYCLES.
REQ-012 The qualifier FSM SHALL have four states: IDLE, QUAL_COIN, WAIT_RELEASE, and QUAL_RELEASE.
REQ-013 In IDLE, a nonzero synchronized value SHALL cause a transition to QUAL_COIN.
REQ-014 In QUAL_COIN, a count reaching DEBOUNCE_CYCLES with a nonzero value SHALL push that code and go to WAIT_RELEASE; a return to 00 SHALL go to IDLE.
REQ-015 In QUAL_COIN, a change to a different nonzero code SHALL stay in QUAL_COIN and restart qualification on the new code.
REQ-016 In WAIT_RELEASE, a synchronized value of 00 SHALL cause a transition to QUAL_RELEASE; any nonzero value SHALL hold WAIT_RELEASE, so a coin held indefinitely is counted once.
REQ-017 In QUAL_RELEASE, 00 held for DEBOUNCE_CYCLES samples SHALL go to IDLE; any nonzero sample SHALL return to WAIT_RELEASE.
REQ-018 Latency: raw code applied before edge 0 and held SHALL appear on coin after edge DEBOUNCE_CYCLES+2 (edge 6 at default) when the FIFO is empty and the emit conditions hold.
REQ-019 The FIFO SHALL be first-in-first-out and SHALL NOT bypass; a push into an empty FIFO is emitted no earlier than the following edge.
REQ-020 At each edge, coin SHALL load the FIFO head, and pop, only if the FIFO is non-empty, coin is currently 00, and drop is currently 0; otherwise coin SHALL load 00.
REQ-021 coin SHALL never be nonzero in two consecutive cycles.
REQ-022 A qualified coin arriving while the FIFO is full with no pop in the same cycle SHALL be discarded, with reject pulsed for exactly one cycle.
REQ-023 A simultaneous push and pop at full SHALL accept the push and pop the head; pending is unchanged and reject stays 0.
REQ-024 A simultaneous push and pop at occupancy 1 SHALL leave pending at 1.
REQ-025 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 pending SHALL be registered and SHALL equal the push count minus the pop count since reset.

Reset
REQ-027 While reset_N is 0 at an edge, the block SHALL set coin=00, reject=0, pending=0, FIFO pointers=0, synchronizer flops=00, debounce count=0, and FSM=IDLE.
REQ-028 A reset asserted mid-qualification or with the FIFO non-empty SHALL discard all pending coins.
REQ-029 After reset, a coin already in the slot SHALL be qualified normally as a fresh insertion.

Structure
REQ-030 The coin-code enum (NONE, CIRCLE, TRIANGLE, PENTAGON) SHALL live in the shared vending package, together with the qualifier state typedef.
REQ-031 The FIFO SHALL be a separate sub-module named coin_fifo with push, pop, data, full, empty, and count ports.

Verification
REQ-032 Scenario 1: after reset, raw 10 held 20 cycles then 00 -> coin=10 for exactly one cycle at edge 6, pending returns to 0, and no second coin is emitted.
REQ-033 Scenario 2: raw 01 toggled to 00 every 2 cycles for 12 cycles (bounce) then held 01 -> exactly one coin=01, emitted 6 edges after the final stable level.
REQ-034 Scenario 3: drop held 1 while the FIFO holds 1 entry -> coin stays 00; the entry is emitted the edge after drop falls.
REQ-035 Scenario 4: five qualified coins (01,10,11,01,10) with drop held 1 -> pending=4, reject pulses once on the fifth; after drop=0, coins emit as 01,10,11,01 with one 00 cycle between each.
REQ-036 Scenario 5: FIFO full and a push coincides with an emit -> pending stays 4 and reject stays 0.
REQ-037 Scenario 6: reset_N pulsed low with pending=3 -> the next cycle shows pending=0 and coin=00, and no stale coin is ever emitted.

Source files
------------

// File: rtl/coin_acceptor_pkg.sv
// Shared vending types: coin codes and coin-qualifier FSM states.
package coin_acceptor_pkg;

   typedef enum logic [1:0] {
      NONE     = 2'b00,
      CIRCLE   = 2'b01,
      TRIANGLE = 2'b10,
      PENTAGON = 2'b11
   } coin_t;

   typedef enum logic [1:0] {
      IDLE,
      QUAL_COIN,
      WAIT_RELEASE,
      QUAL_RELEASE
   } qual_state_t;

endpackage

// File: rtl/coin_acceptor_fifo.sv
// Pending-coin FIFO: no bypass, push at full is only taken alongside a pop.
module coin_fifo
   import coin_acceptor_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clock,
   input  logic                   reset_N,
   input  logic                   push,
   input  logic                   pop,
   input  coin_t                  wdata,
   output coin_t                  rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   coin_t          mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           wr_en;
   logic           rd_en;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clock) begin
      if (!reset_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/coin_acceptor.sv
// Coin slot front end: synchronize, debounce, qualify once per insertion,
// queue accepted coins and hand them to the vending FSM one pulse at a time.
module coin_acceptor
   import coin_acceptor_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                        clock,
   input  logic                        reset_N,
   input  logic [1:0]                  coin_raw,
   input  logic                        drop,
   output logic [1:0]                  coin,
   output logic [$clog2(FIFO_DEPTH):0] pending,
   output logic                        reject
);

   localparam logic [3:0] DEB = 4'(DEBOUNCE_CYCLES);

   logic [1:0]  sync1;
   logic [1:0]  sync2;
   logic [1:0]  samp;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nxt;
   qual_state_t state;
   qual_state_t state_nxt;
   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   coin_t       head;
   coin_t       coin_q;

   // cnt_nxt is the run length including the current sample, so a push is
   // decided on the same edge the count would reach DEBOUNCE_CYCLES.
   always_comb begin
      if (sync2 != samp)    cnt_nxt = 4'd1;
      else if (cnt == DEB)  cnt_nxt = cnt;
      else                  cnt_nxt = cnt + 4'd1;
   end

   always_ff @(posedge clock) begin
      if (!reset_N) begin
         sync1 <= '0;
         sync2 <= '0;
         samp  <= '0;
         cnt   <= '0;
         state <= IDLE;
      end else begin
         sync1 <= coin_raw;
         sync2 <= sync1;
         samp  <= sync2;
         cnt   <= cnt_nxt;
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      case (state)
         IDLE:
            if (sync2 != 2'b00) state_nxt = QUAL_COIN;
         QUAL_COIN:
            if (sync2 == 2'b00) begin
               state_nxt = IDLE;
            end else if (cnt_nxt == DEB) begin
               push      = 1'b1;
               state_nxt = WAIT_RELEASE;
            end
         WAIT_RELEASE:
            if (sync2 == 2'b00) state_nxt = QUAL_RELEASE;
         QUAL_RELEASE:
            if (sync2 != 2'b00)      state_nxt = WAIT_RELEASE;
            else if (cnt_nxt == DEB) state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   assign pop = !empty && (coin_q == NONE) && !drop;

   coin_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .reset_N (reset_N),
      .push    (push),
      .pop     (pop),
      .wdata   (coin_t'(sync2)),
      .rdata   (head),
      .full    (full),
      .empty   (empty),
      .count   (pending)
   );

   always_ff @(posedge clock) begin
      if (!reset_N) begin
         coin_q <= NONE;
         reject <= 1'b0;
      end else begin
         coin_q <= pop ? head : NONE;
         reject <= push && full && !pop;
      end
   end

   assign coin = coin_q;

endmodule
